// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - matrix keypad row sweep, debounce, key encode and history
// Ports:
//   clk_i        system clock, rising edge
//   reset_ni     synchronous active-low reset
//   cols_i       raw column returns, active-low, asynchronous
//   rows_o       row drive, one-hot active-low
//   key_code_o   last accepted key, row*COLS+col
//   key_valid_o  one-cycle pulse per accepted press
//   held_o       high while the accepted key stays pressed
//   history_o    last DEPTH codes, newest in the low slice
module keypad_scan_ctrl #(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int SCAN_DIV = 2000,
  parameter  int DEBOUNCE = 20,
  parameter  int DEPTH    = 2,
  localparam int KEYW     = $clog2(ROWS * COLS)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [COLS-1:0]       cols_i,
  output logic [ROWS-1:0]       rows_o,
  output logic [KEYW-1:0]       key_code_o,
  output logic                  key_valid_o,
  output logic                  held_o,
  output logic [DEPTH*KEYW-1:0] history_o
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE);

  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0]   DB_LAST    = BW'(DEBOUNCE - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROWS_RESET = ~ROWS'(1);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [COLS-1:0]       cols_meta_q, cs_q;
  logic [RW-1:0]         row_q, row_d, next_row;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [BW-1:0]         db_q, db_d;
  logic [CW-1:0]         col_q, col_d, low_col;
  logic [ROWS-1:0]       rows_q;
  logic [KEYW-1:0]       key_code_q, new_code;
  logic                  key_valid_q, held_q;
  logic [DEPTH*KEYW-1:0] history_q;
  logic                  accept, release_done;

  assign next_row = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
  assign new_code = KEYW'(int'(row_q) * COLS + int'(col_q));

  // Descending loop so the lowest low column is the last one written.
  always_comb begin
    low_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cs_q[i]) low_col = CW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    dwell_d      = dwell_q;
    db_d         = db_q;
    col_d        = col_q;
    accept       = 1'b0;
    release_done = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (!(&cs_q)) begin
            state_d = PRESS_DB;
            col_d   = low_col;
            db_d    = '0;
          end else begin
            row_d = next_row;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      PRESS_DB: begin
        if (cs_q[col_q]) begin
          state_d = SCAN;
          row_d   = next_row;
          dwell_d = '0;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
          db_d    = '0;
        end else begin
          db_d = db_q + BW'(1);
        end
      end
      HELD: begin
        // Only the latched column matters; other columns are ignored here.
        if (cs_q[col_q]) begin
          state_d = RELEASE_DB;
          db_d    = '0;
        end
      end
      RELEASE_DB: begin
        if (!cs_q[col_q]) begin
          state_d = HELD;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          release_done = 1'b1;
          state_d      = SCAN;
          row_d        = next_row;
          dwell_d      = '0;
          db_d         = '0;
        end else begin
          db_d = db_q + BW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cols_meta_q <= '1;
      cs_q        <= '1;
      state_q     <= SCAN;
      row_q       <= '0;
      dwell_q     <= '0;
      db_q        <= '0;
      col_q       <= '0;
      rows_q      <= ROWS_RESET;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      held_q      <= 1'b0;
      history_q   <= '0;
    end else begin
      cols_meta_q <= cols_i;
      cs_q        <= cols_meta_q;
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      col_q       <= col_d;
      rows_q      <= ~(ROWS'(1) << row_d);
      key_valid_q <= accept;
      if (accept) begin
        key_code_q          <= new_code;
        held_q              <= 1'b1;
        history_q[KEYW-1:0] <= new_code;
        for (int i = 1; i < DEPTH; i++) begin
          history_q[i*KEYW +: KEYW] <= history_q[(i-1)*KEYW +: KEYW];
        end
      end else if (release_done) begin
        held_q <= 1'b0;
      end
    end
  end

  assign rows_o      = rows_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign held_o      = held_q;
  assign history_o   = history_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic [3:0] cols_i;
  logic [3:0] rows_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       held_o;
  logic [7:0] history_o;

  logic [3:0][3:0] pressed;
  logic [3:0]      force_low;
  logic [3:0]      model_cols;
  logic [3:0]      exp_rows;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] hist;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  logic prev_kv     = 1'b0;

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    model_cols = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && !rows_o[r]) model_cols[c] = 1'b0;
      end
    end
  end

  assign cols_i = model_cols & ~force_low;

  keypad_scan_ctrl #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .DEPTH(2)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .cols_i     (cols_i),
    .rows_o     (rows_o),
    .key_code_o (key_code_o),
    .key_valid_o(key_valid_o),
    .held_o     (held_o),
    .history_o  (history_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: %0d key_valid pulses still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic press_key(input string name, input int r, input int c,
                           input logic [7:0] hist, input int hold);
    exp_t e;
    e.code = 4'(r * 4 + c);
    e.hist = hist;
    sb.push_back(e);
    pressed[r][c] = 1'b1;
    drain(name, 100);
    chk({name, "_held"}, held_o, 1);
    cycles(hold);
  endtask

  task automatic release_all(input string name);
    int n;
    pressed = '0;
    n = 0;
    while (held_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_held_fall"}, held_o, 0);
    cycles(4);
  endtask

  task automatic wait_rows(input string name, input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (rows_o !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, rows_o, target);
  endtask

  initial begin
    reset_ni  = 1'b0;
    pressed   = '0;
    force_low = '0;

    fork
      forever begin
        @(negedge clk);
        if (key_valid_o === 1'b1) begin
          chk("kv_not_back_to_back", prev_kv, 0);
          chk("held_rises_with_kv", held_o, 1);
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_key_valid: got pulse with key_code %0d, expected none", key_code_o);
          end else begin
            mon_e = sb.pop_front();
            chk("key_code", key_code_o, mon_e.code);
            chk("history", history_o, mon_e.hist);
          end
        end
        prev_kv = key_valid_o;
      end
    join_none

    // Reset state
    cycles(4);
    chk("reset_rows", rows_o, 4'b1110);
    chk("reset_key_valid", key_valid_o, 0);
    chk("reset_held", held_o, 0);
    chk("reset_history", history_o, 0);
    chk("reset_key_code", key_code_o, 0);

    // Idle sweep: 4 cycles per row, wrapping
    reset_ni = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_rows = ~(4'b0001 << ((i / 4) % 4));
      chk("sweep_rows", rows_o, exp_rows);
      @(negedge clk);
    end
    chk("sweep_history", history_o, 0);

    // Long press row2/col1 then release timing
    press_key("press_9", 2, 1, 8'h09, 40);
    pressed = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_during_release_db", held_o, 1);
    end
    @(negedge clk);
    chk("held_fall", held_o, 0);
    chk("row_after_release", rows_o, 4'b0111);
    cycles(4);

    // One-cycle glitch on col3 while row1 is driven
    wait_rows("wait_row0", 4'b1110, 40);
    wait_rows("wait_row1", 4'b1101, 40);
    @(negedge clk);
    force_low = 4'b1000;
    @(negedge clk);
    force_low = 4'b0000;
    @(negedge clk);
    chk("glitch_row1_dwell", rows_o, 4'b1101);
    @(negedge clk);
    chk("glitch_row_frozen", rows_o, 4'b1101);
    @(negedge clk);
    chk("glitch_next_row", rows_o, 4'b1011);
    cycles(4);

    // History shifting
    press_key("press_5", 1, 1, 8'h95, 10);
    release_all("rel_5");
    press_key("press_14", 3, 2, 8'h5E, 10);
    release_all("rel_14");
    press_key("press_0", 0, 0, 8'hE0, 10);
    release_all("rel_0");

    // Two columns low on row0, then a third while held
    pressed[0][2] = 1'b1;
    press_key("press_multi", 0, 0, 8'h00, 5);
    pressed[0][3] = 1'b1;
    cycles(30);
    chk("second_key_held", held_o, 1);
    release_all("rel_multi");

    // Short release glitch during HELD, then reset while held
    press_key("press_6", 1, 2, 8'h06, 5);
    pressed[1][2] = 1'b0;
    cycles(2);
    pressed[1][2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("held_through_glitch", held_o, 1);
    end
    reset_ni = 1'b0;
    @(negedge clk);
    chk("midhold_reset_rows", rows_o, 4'b1110);
    chk("midhold_reset_held", held_o, 0);
    chk("midhold_reset_history", history_o, 0);
    chk("midhold_reset_key_valid", key_valid_o, 0);
    chk("midhold_reset_key_code", key_code_o, 0);
    pressed = '0;
    cycles(4);
    reset_ni = 1'b1;
    cycles(40);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
